// File: rtl/mii_rx_deframer.sv
// MII receive deframer: turns a 64-bit/8-lane data/ctrl lane stream into a payload beat stream
// with sof/eof/keep/err, and keeps saturating good-frame and error counters.
module mii_rx_deframer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int MIN_BYTES  = 64,
    parameter int MAX_BYTES  = 1518,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_keep,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic                  o_eof,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);
    localparam int BC_W = $clog2(MAX_BYTES + 2 * CTRL_WIDTH + 1);
    localparam int K_W  = $clog2(CTRL_WIDTH);
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_v, hold_v_d;
    logic                  first_q, first_d;
    logic                  pend_q, pend_d;
    logic                  pend_err_q, pend_err_d;
    logic [CTRL_WIDTH-1:0] pend_keep_q, pend_keep_d;
    logic [BC_W-1:0]       bytecnt_q, bytecnt_d;

    logic [K_W-1:0]        term_lane;
    logic [7:0]            lowest_byte;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [CTRL_WIDTH-1:0] tail_keep;
    logic                  is_data, is_term, has_term, all_idle, is_start, start_ok;
    logic                  short_frame, overflow;

    logic                  emit, e_sof, e_eof, e_err, good_inc;
    logic [DATA_WIDTH-1:0] e_data;
    logic [CTRL_WIDTH-1:0] e_keep;
    logic [1:0]            err_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + (CNT_WIDTH + 1)'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Lane decode: the lowest control lane decides whether this word terminates the frame.
    always_comb begin
        term_lane   = '0;
        lowest_byte = '0;
        tail_data   = '0;
        tail_keep   = '0;
        has_term    = 1'b0;
        all_idle    = 1'b1;
        start_ok    = (i_rx_ctrl == CTRL_WIDTH'(1));
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            if (i_rx_ctrl[i]) begin
                term_lane   = K_W'(i);
                lowest_byte = i_rx_data[8*i +: 8];
            end
        end
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (i_rx_ctrl[i] && i_rx_data[8*i +: 8] == CH_TERM) has_term = 1'b1;
            if (!i_rx_ctrl[i] || i_rx_data[8*i +: 8] != CH_IDLE) all_idle = 1'b0;
            if (i_rx_data[8*i +: 8] != ((i == 0) ? CH_START : (i == CTRL_WIDTH - 1) ? CH_SFD : CH_PRE))
                start_ok = 1'b0;
            if (K_W'(i) < term_lane) begin
                tail_data[8*i +: 8] = i_rx_data[8*i +: 8];
                tail_keep[i]        = 1'b1;
            end
        end
        is_data  = (i_rx_ctrl == '0);
        is_term  = (|i_rx_ctrl) && (lowest_byte == CH_TERM);
        is_start = i_rx_ctrl[0] && (i_rx_data[7:0] == CH_START);
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v;
        first_d     = first_q;
        pend_d      = 1'b0;
        pend_keep_d = pend_keep_q;
        pend_err_d  = pend_err_q;
        bytecnt_d   = bytecnt_q;
        emit        = 1'b0;
        e_data      = hold_q;
        e_keep      = '1;
        e_sof       = 1'b0;
        e_eof       = 1'b0;
        e_err       = 1'b0;
        good_inc    = 1'b0;
        err_inc     = '0;
        short_frame = (int'(bytecnt_q) + int'(term_lane)) < MIN_BYTES;
        overflow    = (int'(bytecnt_q) + CTRL_WIDTH) > MAX_BYTES;

        // A partial tail beat loaded last cycle always owns this output slot.
        if (pend_q) begin
            emit     = 1'b1;
            e_sof    = first_q;
            e_eof    = 1'b1;
            e_err    = pend_err_q;
            e_keep   = pend_keep_q;
            hold_v_d = 1'b0;
            if (pend_err_q) err_inc = 2'd1;
            else            good_inc = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (is_start) begin
                    if (start_ok) begin
                        state_d   = S_PAYLOAD;
                        bytecnt_d = '0;
                        hold_v_d  = 1'b0;
                        first_d   = 1'b1;
                    end else begin
                        state_d = S_DROP;
                        err_inc = err_inc + 2'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (is_data && !overflow) begin
                    emit      = hold_v;
                    e_sof     = first_q;
                    first_d   = first_q && !hold_v;
                    hold_d    = i_rx_data;
                    hold_v_d  = 1'b1;
                    bytecnt_d = bytecnt_q + BC_W'(CTRL_WIDTH);
                end else if (is_term) begin
                    emit     = hold_v;
                    e_sof    = first_q;
                    hold_v_d = 1'b0;
                    state_d  = S_IDLE;
                    if (term_lane == '0) begin
                        e_eof = 1'b1;
                        e_err = short_frame;
                        if (!hold_v || short_frame) err_inc = 2'd1;
                        else                        good_inc = 1'b1;
                    end else begin
                        first_d     = first_q && !hold_v;
                        hold_d      = tail_data;
                        hold_v_d    = 1'b1;
                        pend_d      = 1'b1;
                        pend_keep_d = tail_keep;
                        pend_err_d  = short_frame;
                    end
                end else begin
                    // Overflow, error char, stray control or a new start: close as errored.
                    emit     = hold_v;
                    e_sof    = first_q;
                    e_eof    = 1'b1;
                    e_err    = 1'b1;
                    err_inc  = 2'd1;
                    hold_v_d = 1'b0;
                    if (is_data) begin
                        state_d = S_DROP;
                    end else if (is_start) begin
                        if (start_ok) begin
                            state_d   = S_PAYLOAD;
                            bytecnt_d = '0;
                            first_d   = 1'b1;
                        end else begin
                            state_d = S_DROP;
                            err_inc = 2'd2;
                        end
                    end else begin
                        state_d = has_term ? S_IDLE : S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (has_term || all_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_v      <= 1'b0;
            first_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_err_q  <= 1'b0;
            pend_keep_q <= '0;
            bytecnt_q   <= '0;
            o_data      <= '0;
            o_keep      <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_v      <= hold_v_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            pend_err_q  <= pend_err_d;
            pend_keep_q <= pend_keep_d;
            bytecnt_q   <= bytecnt_d;
            o_valid     <= emit;
            o_data      <= emit ? e_data : '0;
            o_keep      <= emit ? e_keep : '0;
            o_sof       <= emit && e_sof;
            o_eof       <= emit && e_eof;
            o_err       <= emit && e_eof && e_err;
            o_frame_cnt <= sat_add(o_frame_cnt, {1'b0, good_inc});
            o_err_cnt   <= sat_add(o_err_cnt, err_inc);
        end
    end
endmodule
